// File: rtl/cpu_types_pkg.sv
// Shared types for the cache/memory protocol.
//   word_t      : 32-bit address/data word
//   ramstate_t  : state reported by the RAM port
//   arb_state_t : cache_mem_arbiter FSM states
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE,
        I_ACC,
        D_RD,
        D_WR,
        RESP_I,
        RESP_D
    } arb_state_t;

endpackage

// File: rtl/cache_mem_arbiter.sv
// Memory-side responder that arbitrates the icache and dcache ports onto one
// shared RAM port.
//   CLK, nRST               : clock (rising edge), synchronous active-low reset
//   iREN, iaddr             : instruction read request, held until iwait low
//   iwait, iload            : one-cycle-low completion pulse and read data
//   dREN, dWEN, daddr,
//   dstore                  : data read/write request, held until dwait low
//   dwait, dload            : one-cycle-low completion pulse and read data
//   ramREN, ramWEN, ramaddr,
//   ramstore                : RAM strobes, address and write data
//   ramload, ramstate       : RAM read data and status (FREE/BUSY/ACCESS/ERROR)
//   err                     : sticky RAM error/timeout flag, cleared by reset
module cache_mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        err
);

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    arb_state_t  state;
    logic [SW-1:0] starve_cnt;
    logic [TW-1:0] tcnt;

    ramstate_t rs;
    logic      d_req;
    logic      d_win;
    logic      acc_done;
    logic      acc_fail;
    word_t     load_val;

    always_comb begin
        rs       = ramstate_t'(ramstate);
        d_req    = dREN | dWEN;
        // Data normally wins; a saturated starvation count hands the slot
        // to a waiting instruction fetch.
        d_win    = d_req && !((starve_cnt == SW'(STARVE_MAX)) && iREN);
        acc_done = (rs == ACCESS);
        // tcnt counts completed access cycles, so TIMEOUT-1 here means this
        // is the TIMEOUT-th cycle without ACCESS.
        acc_fail = (rs == ERROR) || (tcnt == TW'(TIMEOUT - 1));
        load_val = acc_done ? word_t'(ramload) : '0;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state      <= IDLE;
            iwait      <= 1'b1;
            dwait      <= 1'b1;
            iload      <= '0;
            dload      <= '0;
            ramREN     <= 1'b0;
            ramWEN     <= 1'b0;
            ramaddr    <= '0;
            ramstore   <= '0;
            err        <= 1'b0;
            starve_cnt <= '0;
            tcnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_win) begin
                        // The RAM address/data registers double as the request
                        // latch, so later input changes cannot reach the RAM.
                        ramaddr  <= daddr;
                        ramstore <= dstore;
                        ramWEN   <= dWEN;
                        ramREN   <= ~dWEN;
                        state    <= dWEN ? D_WR : D_RD;
                        tcnt     <= '0;
                        if (iREN) begin
                            if (starve_cnt != SW'(STARVE_MAX))
                                starve_cnt <= starve_cnt + SW'(1);
                        end else begin
                            starve_cnt <= '0;
                        end
                    end else if (iREN) begin
                        ramaddr    <= iaddr;
                        ramstore   <= '0;
                        ramREN     <= 1'b1;
                        ramWEN     <= 1'b0;
                        state      <= I_ACC;
                        tcnt       <= '0;
                        starve_cnt <= '0;
                    end
                end

                I_ACC, D_RD, D_WR: begin
                    if (acc_done || acc_fail) begin
                        ramREN <= 1'b0;
                        ramWEN <= 1'b0;
                        if (!acc_done)
                            err <= 1'b1;
                        if (state == I_ACC) begin
                            iload <= load_val;
                            iwait <= 1'b0;
                            state <= RESP_I;
                        end else begin
                            dload <= load_val;
                            dwait <= 1'b0;
                            state <= RESP_D;
                        end
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end

                RESP_I: begin
                    iwait <= 1'b1;
                    state <= IDLE;
                end

                RESP_D: begin
                    dwait <= 1'b1;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed self-checking bench for cache_mem_arbiter.
module tb_cache_mem_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        err;

    localparam logic [1:0] RS_FREE   = 2'd0;
    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    int n_tests = 0;
    int n_fail  = 0;

    cache_mem_arbiter #(.STARVE_MAX(4), .TIMEOUT(8)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .err      (err)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1);
    end

    initial begin
        nRST = 1'b0; iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
        daddr = '0; dstore = '0; ramload = '0; ramstate = RS_FREE;
        tick(); tick();
        check_eq("rst_iwait",    32'(iwait),    32'd1);
        check_eq("rst_dwait",    32'(dwait),    32'd1);
        check_eq("rst_iload",    iload,         32'h0);
        check_eq("rst_dload",    dload,         32'h0);
        check_eq("rst_strobes",  32'({ramREN, ramWEN}), 32'd0);
        check_eq("rst_ramaddr",  ramaddr,       32'h0);
        check_eq("rst_ramstore", ramstore,      32'h0);
        check_eq("rst_err",      32'(err),      32'd0);
        nRST = 1'b1;
        tick();

        // Zero-wait instruction read (cycle 0 = request seen in IDLE)
        iREN = 1'b1; iaddr = 32'h40; ramstate = RS_ACCESS; ramload = 32'h8C010004;
        tick(); // cycle 1
        check_eq("i0_ramREN",  32'(ramREN), 32'd1);
        check_eq("i0_ramaddr", ramaddr,     32'h40);
        check_eq("i0_iwait_c1", 32'(iwait), 32'd1);
        tick(); // cycle 2
        check_eq("i0_iwait_c2", 32'(iwait), 32'd0);
        check_eq("i0_iload",    iload,      32'h8C010004);
        check_eq("i0_dwait_c2", 32'(dwait), 32'd1);
        iREN = 1'b0;
        tick(); // cycle 3
        check_eq("i0_iwait_c3", 32'(iwait),  32'd1);
        check_eq("i0_ramREN_c3", 32'(ramREN), 32'd0);
        check_eq("i0_iload_hold", iload,     32'h8C010004);

        // Simultaneous instruction read and data write
        iREN = 1'b1; iaddr = 32'h44; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF;
        ramload = 32'h11112222;
        tick(); // c1
        check_eq("sim_strobes",  32'({ramREN, ramWEN}), 32'd1);
        check_eq("sim_ramaddr",  ramaddr,  32'h100);
        check_eq("sim_ramstore", ramstore, 32'hDEADBEEF);
        tick(); // c2
        check_eq("sim_waits_c2", 32'({iwait, dwait}), 32'd2);
        dWEN = 1'b0;
        tick(); // c3
        check_eq("sim_waits_c3", 32'({iwait, dwait}), 32'd3);
        check_eq("sim_idle_strobes", 32'({ramREN, ramWEN}), 32'd0);
        tick(); // c4
        check_eq("sim_i_ramREN",  32'(ramREN), 32'd1);
        check_eq("sim_i_ramaddr", ramaddr,     32'h44);
        tick(); // c5: three cycles after dwait
        check_eq("sim_waits_c5", 32'({iwait, dwait}), 32'd1);
        check_eq("sim_iload",    iload, 32'h11112222);
        iREN = 1'b0;
        tick(); // c6
        check_eq("sim_waits_c6", 32'({iwait, dwait}), 32'd3);

        // Starvation: both requests held, four data grants then one instruction
        iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h200;
        ramstate = RS_ACCESS; ramload = 32'hA5A5A5A5;
        for (int j = 0; j < 6; j++) begin
            tick();
            check_eq("starve_ramaddr", ramaddr, (j == 4) ? 32'h80 : 32'h200);
            tick();
            check_eq("starve_done", 32'({iwait, dwait}), (j == 4) ? 32'd1 : 32'd2);
            if (j == 5) begin
                iREN = 1'b0;
                dREN = 1'b0;
            end
            tick();
            check_eq("starve_gap", 32'({iwait, dwait}), 32'd3);
        end

        // RAM error during an instruction access
        iREN = 1'b1; iaddr = 32'h50; ramstate = RS_FREE; ramload = 32'hFFFFFFFF;
        tick(); // c1
        check_eq("erri_ramREN",  32'(ramREN), 32'd1);
        check_eq("erri_ramaddr", ramaddr,     32'h50);
        ramstate = RS_ERROR;
        tick(); // c2
        check_eq("erri_iwait", 32'(iwait), 32'd0);
        check_eq("erri_iload", iload,      32'h0);
        check_eq("erri_err",   32'(err),   32'd1);
        iREN = 1'b0; ramstate = RS_FREE;
        tick();
        check_eq("erri_iwait_c3", 32'(iwait), 32'd1);
        check_eq("erri_err_c3",   32'(err),   32'd1);
        tick();
        check_eq("erri_err_sticky", 32'(err), 32'd1);

        nRST = 1'b0;
        tick();
        check_eq("rst2_err",   32'(err), 32'd0);
        check_eq("rst2_iload", iload,    32'h0);
        nRST = 1'b1;
        tick();

        // Data read with three BUSY cycles; daddr changes mid-access
        dREN = 1'b1; daddr = 32'h300; ramstate = RS_BUSY; ramload = 32'h12345678;
        tick(); // c1
        check_eq("lat_ramREN",  32'(ramREN), 32'd1);
        check_eq("lat_ramaddr", ramaddr,     32'h300);
        daddr = 32'h999;
        tick(); // c2
        check_eq("lat_ramaddr_c2", ramaddr,    32'h300);
        check_eq("lat_dwait_c2",   32'(dwait), 32'd1);
        tick(); // c3
        check_eq("lat_dwait_c3", 32'(dwait), 32'd1);
        tick(); // c4
        check_eq("lat_dwait_c4", 32'(dwait), 32'd1);
        ramstate = RS_ACCESS;
        tick(); // c5
        check_eq("lat_dwait_c5", 32'(dwait), 32'd0);
        check_eq("lat_dload",    dload,      32'h12345678);
        check_eq("lat_err",      32'(err),   32'd0);
        dREN = 1'b0;
        tick(); // c6
        check_eq("lat_dwait_c6", 32'(dwait), 32'd1);

        // Timeout with TIMEOUT=8: response in cycle 9
        dREN = 1'b1; daddr = 32'h400; ramstate = RS_BUSY;
        for (int c = 1; c <= 8; c++) begin
            tick();
            check_eq("to_dwait_busy", 32'(dwait), 32'd1);
        end
        check_eq("to_err_before", 32'(err), 32'd0);
        tick(); // c9
        check_eq("to_dwait", 32'(dwait), 32'd0);
        check_eq("to_dload", dload,      32'h0);
        check_eq("to_err",   32'(err),   32'd1);
        dREN = 1'b0;
        tick();
        check_eq("to_dwait_c10", 32'(dwait), 32'd1);

        // Reset in the middle of a data read
        dREN = 1'b1; daddr = 32'h500; ramstate = RS_BUSY;
        tick(); // c1
        check_eq("mr_ramREN", 32'(ramREN), 32'd1);
        nRST = 1'b0;
        tick(); // c2
        check_eq("mr_strobes", 32'({ramREN, ramWEN}), 32'd0);
        check_eq("mr_dwait",   32'(dwait), 32'd1);
        check_eq("mr_err",     32'(err),   32'd0);
        check_eq("mr_ramaddr", ramaddr,    32'h0);
        nRST = 1'b1; dREN = 1'b0; ramstate = RS_ACCESS;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_eq("mr_no_pulse", 32'({iwait, dwait}), 32'd3);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Memory-side responder for the cache protocol. It serves the instruction port (iREN/iaddr → iwait/iload) and the data port (dREN/dWEN/daddr/dstore → dwait/dload) of the caches against a single shared RAM port driven by ramstate. The block sits between icache/dcache and RAM. It owns arbitration, request latching, single-cycle completion pulses, starvation avoidance and RAM error/timeout reporting.

## Interface
- STARVE_MAX, 4: maximum consecutive data grants while an instruction request is pending.
- TIMEOUT, 255: maximum cycles in an access state without ramstate==ACCESS before error.
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, synchronous, active-low.
- iREN  in  1  instruction read request, held until iwait low.
- iaddr  in  32  instruction word address.
- iwait  out  1  low for exactly one cycle when iload is valid.
- iload  out  32  instruction data.
- dREN, dWEN  in  1 each  data read/write request, held until dwait low.
- daddr, dstore  in  32 each  data address and write data.
- dwait  out  1  low for exactly one cycle on completion.
- dload  out  32  read data.
- ramREN, ramWEN  out  1 each  RAM strobes.
- ramaddr, ramstore  out  32 each  RAM address and write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- err  out  1  sticky RAM error/timeout flag.

## Operation
- States: IDLE, I_ACC, D_RD, D_WR, RESP_I, RESP_D.
- IDLE arbitration, evaluated every cycle:
  - Data request wins over instruction, unless starve_cnt==STARVE_MAX and iREN=1; then instruction wins.
  - dREN and dWEN both high is treated as a write.
- Latching: on grant, address, store data and request type are latched. Input changes during the access are ignored.
- Access states drive ramaddr/ramstore from the latched values, with ramREN (I_ACC, D_RD) or ramWEN (D_WR) high. Strobes are low in all other states.
- Leaving an access state:
  - ramstate==ACCESS: register ramload into the load register, then go to the matching RESP state.
  - ramstate==ERROR, or timeout counter reaches TIMEOUT: set err, load register = 0, go to RESP.
- RESP_I drives iwait=0; RESP_D drives dwait=0. The load output is valid in that cycle. Next state is always IDLE.
- starve_cnt (width clog2(STARVE_MAX+1)):
  - Increments on each data grant while iREN=1.
  - Clears on an instruction grant, or on a data grant with iREN=0.
  - Saturates at STARVE_MAX.
- Timeout counter: clears on entering any access state, increments each access cycle.
- A requester that drops its request mid-access does not abort the access. The RAM transaction completes and the RESP pulse is still issued.
- err is cleared only by reset.

## Timing
- Reset values:
  - State IDLE.
  - iwait=dwait=1.
  - iload=dload=0.
  - ramREN=ramWEN=0, ramaddr=ramstore=0.
  - err=0.
  - starve_cnt=0, timeout counter=0.
- A synchronous reset mid-access returns the block to IDLE at that edge. The in-flight response is dropped; no wait-low pulse is issued.
- Zero-wait RAM (ACCESS in the first access cycle):
  - Request seen in IDLE at cycle 0.
  - RAM strobe in cycle 1.
  - wait low in cycle 2.
  - IDLE in cycle 3.
- Each BUSY cycle adds one cycle of latency.
- Back-to-back: a request still held in IDLE re-arbitrates immediately, giving one completion per 3 cycles at best.
- Waits are never low for both ports in the same cycle, and never low for more than one cycle per transaction.
- iload and dload hold their last value outside RESP states.

## Structure
- ramstate_t (FREE/BUSY/ACCESS/ERROR) and arb_state_t belong in cpu_types_pkg. word_t is used for all 32-bit fields.
- Single module; no sub-module. The counters and FSM are local.

## Test plan
- Zero-wait instruction read: iREN=1, iaddr=0x40, ramload=0x8C010004 with ramstate=ACCESS → ramREN high in cycle 1 with ramaddr=0x40; iwait=0 and iload=0x8C010004 in cycle 2 only.
- Simultaneous requests: iREN=1 and dWEN=1, daddr=0x100, dstore=0xDEADBEEF → data granted first with ramWEN=1; dwait low; the instruction is then served; iwait goes low 3 cycles after dwait.
- Starvation: iREN held, dREN re-asserted continuously, STARVE_MAX=4 → 4 data completions, then an instruction completion, then data resumes.
- RAM latency: ramstate=BUSY for 3 cycles, then ACCESS → dwait low in cycle 5. Mid-access changes to daddr do not alter ramaddr.
- Error/timeout:
  - ramstate=ERROR during I_ACC → iwait pulse with iload=0, and err=1 until reset.
  - Separately, TIMEOUT=8 with ramstate stuck at BUSY → response after 8 access cycles, and err=1.
- Reset mid-access: nRST low during D_RD → next edge IDLE, strobes low, dwait=1, err=0, no completion pulse issued.
